heater_supervisor: RTL and testbench
====================================

# heater_supervisor

Hardware sequencer that drives the enable/err_clear side of the heater array and consumes each heater's `error` output, replacing manual VIO control. On `start` it enables the heaters one at a time to limit inrush. In run it recovers tripped heaters automatically: disable, clear pulse, hold-off, re-enable. A channel that exceeds a retry budget is locked out. It sits between the top level and the N `heater` instances; the VIO keeps only `start`/`stop` and status readback.

## Interface
- `N`, 18, number of heater channels (1..32)
- `STAGGER_CYCLES`, 1024, cycles between successive channel enables during ramp (>=1)
- `CLEAR_CYCLES`, 4, width of the `heater_err_clear` pulse (>=1)
- `HOLDOFF_CYCLES`, 256, idle cycles after the clear pulse before re-enable (>=1)
- `MAX_RETRY`, 3, recoveries allowed per channel before lockout (0..15)

- `clk` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `start` in 1: level. Begins a ramp when sampled high in IDLE.
- `stop` in 1: level. Forces IDLE from any state.
- `heater_error` in N: per-channel error from the heaters
- `heater_enable` out N: per-channel enable
- `heater_err_clear` out N: per-channel error-clear pulse
- `fault` out N: sticky lockout flag per channel
- `busy` out 1: high whenever the top FSM is not IDLE

## Operation
- Top FSM states:
  - IDLE: all outputs low except `fault`, which holds its value.
  - RAMP: `start` in IDLE clears `fault`, the retry counters and `pending`. `heater_enable[0]` rises the next cycle. `heater_enable[k]` rises k*STAGGER_CYCLES cycles after `heater_enable[0]`. RUN is entered the cycle after `heater_enable[N-1]` rises.
  - RUN: remains in RUN until `stop`.
  - `stop` high in any state: the next cycle is IDLE, all enables and clears are 0, any recovery is aborted, and `pending` is cleared.
  - `stop` and `start` high together in IDLE: `stop` wins and the FSM stays IDLE.
- Error capture, in RAMP or RUN:
  - `pending[i]` is set when `heater_error[i]`=1, `heater_enable[i]`=1, `fault[i]`=0 and channel i is not under recovery.
  - Errors are only captured, not serviced, during RAMP.
- Recovery engine (RUN only, one channel at a time):
  - R_IDLE selects the lowest-index pending channel i and clears `pending[i]`.
  - R_CLEAR: `heater_enable[i]`=0 and `heater_err_clear[i]`=1 for exactly CLEAR_CYCLES.
  - R_HOLD: both signals 0 for HOLDOFF_CYCLES.
  - Exit from R_HOLD:
    - If `retry[i]`==MAX_RETRY, set `fault[i]` and leave `heater_enable[i]` at 0.
    - Otherwise increment `retry[i]` and set `heater_enable[i]`=1.
  - The engine returns to R_IDLE and can select the next channel on the following cycle.
- `retry[i]` is 4 bits and saturates at MAX_RETRY. It is never decremented within a run.
- A locked-out channel stays disabled until the next `start` or `rst`.

## Timing
- After `rst`: state IDLE, and every output is 0, including `fault`.
- Latency from `start` to the first enable: 1 cycle. Latency from `stop` to all enables low: 1 cycle.
- Latency from `heater_error[i]` high (captured) to `heater_err_clear[i]` high:
  - 2 cycles if the engine is idle.
  - Otherwise queued behind the recovery in progress.
- One recovery takes CLEAR_CYCLES+HOLDOFF_CYCLES cycles from the first clear cycle to re-enable.
- `heater_err_clear` is never asserted on more than one channel at a time, and never while that channel's enable is high.
- Every output is a register; there are no combinational input-to-output paths.

## Configuration
- `HEATER_SUP_STAGGER_EN`
  - Defined: staggered ramp as described above.
  - Undefined: RAMP lasts one cycle. All N enables rise together 1 cycle after `start`, and RUN follows on the next cycle. The stagger counter is not instantiated and STAGGER_CYCLES is ignored.

## Structure
- Shared package `heater_pkg`:
  - top-state enum (IDLE, RAMP, RUN)
  - recovery-state enum (R_IDLE, R_CLEAR, R_HOLD)
  - `RETRY_W`=4
- Sub-module `heater_recovery`:
  - Contains the serial recovery FSM, the lowest-index priority pick, the clear/hold-off counter and the retry array.
  - Its ports are `pending`, `run`, `abort`, the selected-index enable override, and `heater_err_clear`/`fault`.
- The top module holds the top FSM, the stagger counter and the enable register.

## Test plan
All scenarios use N=4, STAGGER_CYCLES=4, CLEAR_CYCLES=2, HOLDOFF_CYCLES=8, MAX_RETRY=2, with `HEATER_SUP_STAGGER_EN` defined unless stated.
- **Ramp:** `start` pulse at cycle 0 → enables 0001 at 1, 0011 at 5, 0111 at 9, 1111 at 13; RUN at 14; `busy` high from 1.
- **Single recovery:** in RUN, raise `heater_error[2]` for 1 cycle → `heater_enable[2]` low and `heater_err_clear[2]` high for 2 cycles, then 8 idle cycles, then `heater_enable[2]` high again.
- **Simultaneous errors:** errors on channels 1 and 3 in the same cycle → channel 1 is recovered first; channel 3's clear starts 10 cycles after channel 1's clear.
- **Lockout:** hold `heater_error[0]` high → 2 recoveries, then on the 3rd trip `fault[0]`=1 and `heater_enable[0]` stays 0; the other channels are unaffected.
- **Stop mid-recovery:** `stop` during R_CLEAR of channel 2 → next cycle all enables and clears are 0 and the state is IDLE; `fault` is retained; a later `start` clears `fault`.
- **Macro undefined:** `start` → `heater_enable`=1111 exactly 1 cycle later.

Source files
------------

// File: rtl/heater_pkg.sv
// Shared types for the heater supervisor: top/recovery FSM states and retry counter width.
package heater_pkg;

  typedef enum logic [1:0] {StIdle, StRamp, StRun} top_state_e;

  typedef enum logic [1:0] {RIdle, RClear, RHold} rec_state_e;

  localparam int unsigned RETRY_W = 4;

endpackage

// File: rtl/heater_recovery.sv
// Serial recovery engine: lowest-index pick, clear pulse, hold-off, retry budget and lockout.
module heater_recovery
  import heater_pkg::*;
#(
  parameter int unsigned N              = 18,
  parameter int unsigned CLEAR_CYCLES   = 4,
  parameter int unsigned HOLDOFF_CYCLES = 256,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         run_i,
  input  logic         abort_i,
  input  logic         clear_i,
  input  logic [N-1:0] pending_i,
  output logic [N-1:0] take_o,
  output logic [N-1:0] active_o,
  output logic [N-1:0] en_set_o,
  output logic [N-1:0] heater_err_clear_o,
  output logic [N-1:0] fault_o
);

  localparam int unsigned IdxW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntMax = (CLEAR_CYCLES > HOLDOFF_CYCLES) ? CLEAR_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0]    ClearLast = CntW'(CLEAR_CYCLES - 1);
  localparam logic [CntW-1:0]    HoldLast  = CntW'(HOLDOFF_CYCLES - 1);
  localparam logic [RETRY_W-1:0] MaxRetry  = RETRY_W'(MAX_RETRY);

  rec_state_e         state_q, state_d;
  logic [IdxW-1:0]    sel_q, sel_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]       clr_q, clr_d;
  logic [N-1:0]       fault_q, fault_d;
  logic [RETRY_W-1:0] retry_q [N];
  logic [RETRY_W-1:0] retry_d [N];

  logic [IdxW-1:0] pick_idx;
  logic            pick_vld;
  logic            hold_done;

  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (pending_i[i] && !pick_vld) begin
        pick_idx = IdxW'(i);
        pick_vld = 1'b1;
      end
    end
  end

  assign hold_done = (state_q == RHold) && (cnt_q == HoldLast);

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    clr_d    = clr_q;
    fault_d  = fault_q;
    retry_d  = retry_q;
    take_o   = '0;
    en_set_o = '0;
    active_o = (state_q != RIdle) ? (N'(1) << sel_q) : '0;

    case (state_q)
      RClear: begin
        if (cnt_q == ClearLast) begin
          state_d = RHold;
          cnt_d   = '0;
          clr_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RHold: begin
        if (hold_done) begin
          state_d = RIdle;
          if (retry_q[sel_q] == MaxRetry) begin
            fault_d[sel_q] = 1'b1;
          end else begin
            retry_d[sel_q]  = retry_q[sel_q] + RETRY_W'(1);
            en_set_o[sel_q] = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: ;
    endcase

    // Picking on the final hold-off cycle lets queued channels run back to back.
    if (run_i && pick_vld && (state_q == RIdle || hold_done)) begin
      state_d          = RClear;
      sel_d            = pick_idx;
      cnt_d            = '0;
      clr_d            = N'(1) << pick_idx;
      take_o           = N'(1) << pick_idx;
      active_o         = active_o | take_o;
    end

    if (abort_i) begin
      state_d  = RIdle;
      cnt_d    = '0;
      clr_d    = '0;
      en_set_o = '0;
      fault_d  = fault_q;
      retry_d  = retry_q;
    end

    if (clear_i) begin
      fault_d = '0;
      for (int i = 0; i < N; i++) retry_d[i] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RIdle;
      sel_q   <= '0;
      cnt_q   <= '0;
      clr_q   <= '0;
      fault_q <= '0;
      for (int i = 0; i < N; i++) retry_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      fault_q <= fault_d;
      retry_q <= retry_d;
    end
  end

  assign heater_err_clear_o = clr_q;
  assign fault_o            = fault_q;

endmodule

// File: rtl/heater_supervisor.sv
// Heater array sequencer: top FSM, ramp enables, error capture. Define HEATER_SUP_STAGGER_EN
// for a staggered ramp; otherwise all channels are enabled together.
module heater_supervisor
  import heater_pkg::*;
#(
  parameter int unsigned N              = 18,
  parameter int unsigned STAGGER_CYCLES = 1024,
  parameter int unsigned CLEAR_CYCLES   = 4,
  parameter int unsigned HOLDOFF_CYCLES = 256,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic         stop_i,
  input  logic [N-1:0] heater_error_i,
  output logic [N-1:0] heater_enable_o,
  output logic [N-1:0] heater_err_clear_o,
  output logic [N-1:0] fault_o,
  output logic         busy_o
);

  top_state_e   state_q, state_d;
  logic [N-1:0] enable_q, enable_d;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] capture;
  logic [N-1:0] rec_take, rec_active, rec_en_set;

`ifdef HEATER_SUP_STAGGER_EN
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned StgW = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
  localparam logic [StgW-1:0] StgLast = StgW'(STAGGER_CYCLES - 1);

  logic [StgW-1:0] stg_cnt_q, stg_cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stg_cnt_q <= '0;
      idx_q     <= '0;
    end else begin
      stg_cnt_q <= stg_cnt_d;
      idx_q     <= idx_d;
    end
  end
`else
  logic unused_stagger;
  assign unused_stagger = ^STAGGER_CYCLES;
`endif

  always_comb begin
    state_d   = state_q;
    enable_d  = enable_q;
    pending_d = pending_q;
    capture   = heater_error_i & enable_q & ~fault_o & ~rec_active;
`ifdef HEATER_SUP_STAGGER_EN
    stg_cnt_d = stg_cnt_q;
    idx_d     = idx_q;
`endif

    case (state_q)
      StIdle: begin
        enable_d  = '0;
        pending_d = '0;
        if (start_i) begin
          state_d = StRamp;
`ifdef HEATER_SUP_STAGGER_EN
          enable_d  = N'(1);
          stg_cnt_d = '0;
          idx_d     = IdxW'(1);
`else
          enable_d = '1;
`endif
        end
      end
      StRamp: begin
        pending_d = pending_q | capture;
        if (enable_q[N-1]) begin
          state_d = StRun;
`ifdef HEATER_SUP_STAGGER_EN
        end else if (stg_cnt_q == StgLast) begin
          stg_cnt_d       = '0;
          enable_d[idx_q] = 1'b1;
          idx_d           = idx_q + IdxW'(1);
        end else begin
          stg_cnt_d = stg_cnt_q + StgW'(1);
`endif
        end
      end
      StRun: begin
        enable_d  = (enable_q & ~rec_take) | rec_en_set;
        pending_d = (pending_q & ~rec_take) | capture;
      end
      default: state_d = StIdle;
    endcase

    if (stop_i) begin
      state_d   = StIdle;
      enable_d  = '0;
      pending_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      enable_q  <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
    end
  end

  heater_recovery #(
    .N             (N),
    .CLEAR_CYCLES  (CLEAR_CYCLES),
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
    .MAX_RETRY     (MAX_RETRY)
  ) u_recovery (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .run_i             (state_q == StRun),
    .abort_i           (stop_i),
    .clear_i           ((state_q == StIdle) && start_i && !stop_i),
    .pending_i         (pending_q),
    .take_o            (rec_take),
    .active_o          (rec_active),
    .en_set_o          (rec_en_set),
    .heater_err_clear_o(heater_err_clear_o),
    .fault_o           (fault_o)
  );

  assign heater_enable_o = enable_q;
  assign busy_o          = (state_q != StIdle);

endmodule

// File: tb/tb_heater_supervisor.sv
// Directed bench for heater_supervisor (N=4, stagger 4, clear 2, hold-off 8, retry 2).
module tb_heater_supervisor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [3:0] err;
  logic [3:0] en;
  logic [3:0] clr;
  logic [3:0] fault;
  logic       busy;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  heater_supervisor #(
    .N             (4),
    .STAGGER_CYCLES(4),
    .CLEAR_CYCLES  (2),
    .HOLDOFF_CYCLES(8),
    .MAX_RETRY     (2)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .start_i           (start),
    .stop_i            (stop),
    .heater_error_i    (err),
    .heater_enable_o   (en),
    .heater_err_clear_o(clr),
    .fault_o           (fault),
    .busy_o            (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks enable/clear for n consecutive cycles, advancing one cycle after each.
  task automatic hold_cycles(input int n, input logic [3:0] exp_en, input logic [3:0] exp_clr,
                             input string tag);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_en"}, 32'(en), 32'(exp_en));
      chk({tag, "_clr"}, 32'(clr), 32'(exp_clr));
      tick();
    end
  endtask

  logic [3:0] exp_ramp;
  logic [3:0] first_en;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    err   = '0;
`ifdef HEATER_SUP_STAGGER_EN
    first_en = 4'b0001;
`else
    first_en = 4'b1111;
`endif
    tick();
    tick();
    rst = 1'b0;
    chk("rst_en", 32'(en), 32'h0);
    chk("rst_clr", 32'(clr), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Ramp: start sampled at cycle 0, checks cycles 1..15.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
`ifdef HEATER_SUP_STAGGER_EN
      exp_ramp = '0;
      for (int k = 0; k < 4; k++) if (c >= 1 + 4 * k) exp_ramp[k] = 1'b1;
`else
      exp_ramp = 4'b1111;
`endif
      chk("ramp_en", 32'(en), 32'(exp_ramp));
      chk("ramp_busy", 32'(busy), 32'h1);
      tick();
    end

    // Single recovery on channel 2.
    err = 4'b0100;
    tick();
    err = '0;
    hold_cycles(1, 4'b1111, 4'b0000, "single_pick");
    hold_cycles(2, 4'b1011, 4'b0100, "single_clear");
    hold_cycles(8, 4'b1011, 4'b0000, "single_hold");
    hold_cycles(1, 4'b1111, 4'b0000, "single_reen");

    // Simultaneous errors on 1 and 3: channel 3 clears 10 cycles after channel 1.
    err = 4'b1010;
    tick();
    err = '0;
    hold_cycles(1, 4'b1111, 4'b0000, "dual_pick");
    hold_cycles(2, 4'b1101, 4'b0010, "dual_clear1");
    hold_cycles(8, 4'b1101, 4'b0000, "dual_hold1");
    hold_cycles(2, 4'b0111, 4'b1000, "dual_clear3");
    hold_cycles(8, 4'b0111, 4'b0000, "dual_hold3");
    hold_cycles(1, 4'b1111, 4'b0000, "dual_reen");

    // Lockout: channel 0 stuck in error.
    err = 4'b0001;
    tick();
    hold_cycles(1, 4'b1111, 4'b0000, "lock_pick0");
    for (int r = 0; r < 2; r++) begin
      hold_cycles(2, 4'b1110, 4'b0001, "lock_clear");
      chk("lock_fault_hold", 32'(fault), 32'h0);
      hold_cycles(8, 4'b1110, 4'b0000, "lock_hold");
      hold_cycles(2, 4'b1111, 4'b0000, "lock_reen");
    end
    hold_cycles(2, 4'b1110, 4'b0001, "lock_clear_last");
    hold_cycles(8, 4'b1110, 4'b0000, "lock_hold_last");
    chk("lock_fault", 32'(fault), 32'h1);
    hold_cycles(4, 4'b1110, 4'b0000, "lock_stays_off");
    chk("lock_fault_sticky", 32'(fault), 32'h1);
    err = '0;

    // Stop during channel 2 clear.
    err = 4'b0100;
    tick();
    err = '0;
    tick();
    chk("stop_pre_clr", 32'(clr), 32'h4);
    chk("stop_pre_en", 32'(en), 32'ha);
    stop = 1'b1;
    tick();
    chk("stop_en", 32'(en), 32'h0);
    chk("stop_clr", 32'(clr), 32'h0);
    chk("stop_busy", 32'(busy), 32'h0);
    chk("stop_fault_kept", 32'(fault), 32'h1);

    // Start and stop together: stop wins, fault untouched.
    start = 1'b1;
    tick();
    chk("both_busy", 32'(busy), 32'h0);
    chk("both_en", 32'(en), 32'h0);
    chk("both_fault", 32'(fault), 32'h1);
    stop = 1'b0;
    tick();
    start = 1'b0;
    chk("restart_fault", 32'(fault), 32'h0);
    chk("restart_en", 32'(en), 32'(first_en));
    chk("restart_busy", 32'(busy), 32'h1);

    // Reset mid-ramp returns everything to zero.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_en", 32'(en), 32'h0);
    chk("rst2_busy", 32'(busy), 32'h0);
    chk("rst2_fault", 32'(fault), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
